fifo_uart_tx: RTL

- Downstream consumer of the 8-bit synchronous FIFO.
- Pops one word at a time using the FIFO's read-enable / registered-dout protocol.
- Serializes each word onto a UART line as 8N1, LSB first.
- Together with the FIFO it forms the board's buffered serial transmit path.

---
 rtl/fifo_uart_tx_pkg.sv | 17 +
 rtl/fifo_uart_tx_if.sv | 15 +
 rtl/uart_baud_tick.sv | 29 ++
 rtl/fifo_uart_tx.sv | 128 ++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared constants for the buffered serial transmit path: frame geometry,
// line idle level and the transmitter state encoding.
package fifo_uart_tx_pkg;

    localparam int   DEFAULT_DWIDTH       = 8;
    localparam int   DEFAULT_CLKS_PER_BIT = 434;   // 50 MHz / 115200 baud
    localparam logic UART_IDLE_LEVEL      = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port as seen between the FIFO (slave) and its consumer (master).
interface fifo_uart_tx_if
    import fifo_uart_tx_pkg::*;
#(
    parameter int DWIDTH = DEFAULT_DWIDTH
);

    logic              fifo_empty;
    logic [DWIDTH-1:0] fifo_dout;
    logic              fifo_rd_en;

    modport master (input fifo_empty, input fifo_dout, output fifo_rd_en);
    modport slave  (output fifo_empty, output fifo_dout, input fifo_rd_en);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// terminal count as a one-cycle tick; clear forces it back to zero.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    // Returning to zero at the tick keeps the count from ever passing TERM.
    always_ff @(posedge clk) begin
        if (rst || i_clr || o_tick) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick = i_en && (r_cnt == TERM);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a registered-output FIFO and sends each one as an 8N1
// UART frame, LSB first.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DWIDTH       = DEFAULT_DWIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tx_en,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           busy,
    output logic           frame_done
);

    localparam int            IW       = $clog2(DWIDTH + 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DWIDTH - 1);

    tx_state_t         r_state;
    tx_state_t         w_state_next;
    logic [DWIDTH-1:0] r_shreg;
    logic [DWIDTH-1:0] w_shreg_next;
    logic [IW-1:0]     r_bit_idx;
    logic [IW-1:0]     w_bit_idx_next;
    logic              r_tx;
    logic              w_tx_next;
    logic              r_busy;
    logic              r_frame_done;
    logic              w_done_next;
    logic              w_rd_en;
    logic              w_baud_en;
    logic              w_baud_clr;
    logic              w_tick;

    assign w_rd_en         = (r_state == ST_IDLE) && tx_en && !fifo.fifo_empty && !rst;
    assign fifo.fifo_rd_en = w_rd_en;

    assign w_baud_en  = (r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP);
    assign w_baud_clr = (w_state_next != r_state);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_baud_en),
        .i_clr (w_baud_clr),
        .o_tick(w_tick)
    );

    always_comb begin
        w_state_next   = r_state;
        w_shreg_next   = r_shreg;
        w_bit_idx_next = r_bit_idx;
        w_done_next    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rd_en) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_shreg_next   = fifo.fifo_dout;
                w_bit_idx_next = '0;
                w_state_next   = ST_START;
            end
            ST_START: begin
                if (w_tick) begin
                    w_bit_idx_next = '0;
                    w_state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shreg_next   = r_shreg >> 1;
                    w_bit_idx_next = r_bit_idx + IW'(1);
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // The line level is registered from the next state so tx never glitches.
    always_comb begin
        w_tx_next = UART_IDLE_LEVEL;
        case (w_state_next)
            ST_START: w_tx_next = ~UART_IDLE_LEVEL;
            ST_DATA:  w_tx_next = w_shreg_next[0];
            default:  w_tx_next = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_bit_idx    <= '0;
            r_tx         <= UART_IDLE_LEVEL;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_shreg      <= w_shreg_next;
            r_bit_idx    <= w_bit_idx_next;
            r_tx         <= w_tx_next;
            r_busy       <= (w_state_next != ST_IDLE);
            r_frame_done <= w_done_next;
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
